// File: rtl/fifo_pkg.sv
// Shared constants and state type for the delay-fifo loader.
// Defaults match the downstream delay fifo geometry.
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_BITS  = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } loader_state_e;

endpackage

// File: rtl/loader_buf.sv
// Staging storage for the loader: one write port, one async read port.
// Contents are deliberately not reset.
module loader_buf #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [BITS-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [BITS-1:0] rdata
);

    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_loader.sv
// Stages upstream words, then shifts them into a delay fifo followed by
// DEPTH zero words so every staged word reaches the fifo output.
module fifo_loader
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = DEFAULT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [BITS-1:0]            in_data,
    output logic                       in_ready,
    input  logic                       start,
    output logic                       fifo_en,
    output logic [BITS-1:0]            fifo_d,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    loader_state_e   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            fifo_en_q, fifo_en_d;
    logic [BITS-1:0] fifo_d_q, fifo_d_d;
    logic            done_q, done_d;

    logic            accept;
    logic [CW-1:0]   count_post;
    logic [BITS-1:0] rd_data;

    assign in_ready   = (state_q == LOAD) && (count_q < CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign count_post = count_q + CW'(accept);

    loader_buf #(
        .DEPTH (DEPTH),
        .BITS  (BITS),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        flush_cnt_d = flush_cnt_q;
        fifo_en_d   = 1'b0;
        fifo_d_d    = '0;
        done_d      = 1'b0;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        unique case (state_q)
            LOAD: begin
                count_d = count_post;
                if (start && (count_post != '0)) begin
                    // With nothing staged yet, word 0 is the one arriving now.
                    state_d   = DRAIN;
                    fifo_en_d = 1'b1;
                    fifo_d_d  = (count_q == '0) ? in_data : rd_data;
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    count_d   = count_post - CW'(1);
                end
            end
            DRAIN: begin
                fifo_en_d = 1'b1;
                if (count_q != '0) begin
                    fifo_d_d = rd_data;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                end else begin
                    state_d     = FLUSH;
                    flush_cnt_d = CW'(1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == CW'(DEPTH)) begin
                    state_d     = LOAD;
                    done_d      = 1'b1;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    flush_cnt_d = '0;
                end else begin
                    fifo_en_d   = 1'b1;
                    flush_cnt_d = flush_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            flush_cnt_q <= '0;
            fifo_en_q   <= 1'b0;
            fifo_d_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            flush_cnt_q <= flush_cnt_d;
            fifo_en_q   <= fifo_en_d;
            fifo_d_q    <= fifo_d_d;
            done_q      <= done_d;
        end
    end

    assign fifo_en = fifo_en_q;
    assign fifo_d  = fifo_d_q;
    assign count   = count_q;
    assign busy    = (state_q != LOAD);
    assign done    = done_q;

endmodule

// File: tb/tb_fifo_loader.sv
// Self-checking bench for fifo_loader with a behavioural downstream
// delay fifo and a scoreboard of staged words.
module tb_fifo_loader;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            in_ready;
    logic            start;
    logic            fifo_en;
    logic [BITS-1:0] fifo_d;
    logic [CW-1:0]   count;
    logic            busy;
    logic            done;

    fifo_loader #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .fifo_en  (fifo_en),
        .fifo_d   (fifo_d),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Downstream delay fifo: DEPTH-stage shift register, q is the last stage.
    logic [BITS-1:0] ds_sr [DEPTH];
    always_ff @(posedge clk) begin
        if (fifo_en) begin
            ds_sr[0] <= fifo_d;
            for (int k = 1; k < DEPTH; k++) begin
                ds_sr[k] <= ds_sr[k-1];
            end
        end
    end

    typedef struct {
        int              offer;
        logic [BITS-1:0] base;
        bit              same;
        int              exp_count;
    } vec_t;

    vec_t            vecs [4];
    logic [BITS-1:0] exp_q [$];
    int              n_pass  = 0;
    int              n_total = 0;

    task automatic chk(input string name, input logic [BITS-1:0] act,
                       input logic [BITS-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int offer, input logic [BITS-1:0] base,
                        input bit same);
        int acc = 0;
        for (int i = 0; i < offer; i++) begin
            in_valid = 1'b1;
            in_data  = base + BITS'(i);
            start    = same && (i == offer - 1);
            #1;
            chk("in_ready_load", BITS'(in_ready), BITS'(acc < DEPTH));
            if (acc < DEPTH) begin
                exp_q.push_back(in_data);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Called in cycle T (do_start) or in T+1 when start rode with the load.
    task automatic run_drain(input bit do_start, input int inject_at,
                             input int rst_at);
        logic [BITS-1:0] drained [$];
        logic [BITS-1:0] exp_d;
        int n;
        int idx;
        n = exp_q.size();
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int j = 1; j <= n + DEPTH; j++) begin
            chk("fifo_en", BITS'(fifo_en), BITS'(1));
            chk("busy", BITS'(busy), BITS'(1));
            chk("done_early", BITS'(done), BITS'(0));
            if (j <= n) begin
                exp_d = exp_q.pop_front();
                drained.push_back(exp_d);
            end else begin
                exp_d = '0;
            end
            chk("fifo_d", fifo_d, exp_d);
            idx = j - DEPTH - 1;
            if (idx >= 0) begin
                chk("ds_q", ds_sr[DEPTH-1], drained[idx]);
            end
            if (j == inject_at) begin
                chk("in_ready_drain", BITS'(in_ready), BITS'(0));
                start    = 1'b1;
                in_valid = 1'b1;
                in_data  = 'hDEAD;
            end
            if (j == rst_at) begin
                rst = 1'b1;
            end
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            if (rst) begin
                rst = 1'b0;
                chk("rst_fifo_en", BITS'(fifo_en), BITS'(0));
                chk("rst_count", BITS'(count), BITS'(0));
                chk("rst_in_ready", BITS'(in_ready), BITS'(1));
                chk("rst_busy", BITS'(busy), BITS'(0));
                for (int c = 0; c < n + DEPTH + 2; c++) begin
                    chk("rst_no_done", BITS'(done), BITS'(0));
                    chk("rst_no_en", BITS'(fifo_en), BITS'(0));
                    tick();
                end
                exp_q.delete();
                return;
            end
        end
        chk("done", BITS'(done), BITS'(1));
        chk("end_count", BITS'(count), BITS'(0));
        chk("end_in_ready", BITS'(in_ready), BITS'(1));
        chk("end_fifo_en", BITS'(fifo_en), BITS'(0));
        chk("end_fifo_d", fifo_d, '0);
        chk("end_busy", BITS'(busy), BITS'(0));
        tick();
        chk("done_pulse", BITS'(done), BITS'(0));
    endtask

    initial begin
        vecs[0] = '{offer: 3,  base: 'hA,   same: 1'b0, exp_count: 3};
        vecs[1] = '{offer: 10, base: 'h1,   same: 1'b0, exp_count: 8};
        vecs[2] = '{offer: 1,  base: 'h55,  same: 1'b1, exp_count: 1};
        vecs[3] = '{offer: 5,  base: 'h100, same: 1'b0, exp_count: 5};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_fifo_en", BITS'(fifo_en), BITS'(0));
        chk("rst_fifo_d", fifo_d, '0);
        chk("rst_done", BITS'(done), BITS'(0));
        chk("rst_busy", BITS'(busy), BITS'(0));
        chk("rst_count", BITS'(count), BITS'(0));
        chk("rst_in_ready", BITS'(in_ready), BITS'(1));

        // start with nothing staged is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("idle_en", BITS'(fifo_en), BITS'(0));
            chk("idle_done", BITS'(done), BITS'(0));
            chk("idle_busy", BITS'(busy), BITS'(0));
            tick();
        end

        for (int v = 0; v < 4; v++) begin
            load(vecs[v].offer, vecs[v].base, vecs[v].same);
            if (!vecs[v].same) begin
                chk("load_count", BITS'(count), BITS'(vecs[v].exp_count));
                chk("load_in_ready", BITS'(in_ready),
                    BITS'(vecs[v].exp_count < DEPTH));
            end
            run_drain(!vecs[v].same, 0, 0);
            tick();
        end

        // start and in_valid during DRAIN are ignored
        load(4, 'h40, 1'b0);
        run_drain(1'b1, 2, 0);
        tick();

        // reset at T+5 during a drain of four words
        load(4, 'h70, 1'b0);
        run_drain(1'b1, 0, 5);

        // loader still usable after the mid-drain reset
        load(2, 'h90, 1'b0);
        run_drain(1'b1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
